// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Shares a single-port memory between the debug Controller and
//                the core under test. One transaction in flight, registered
//                request path, strobes held until mem_response, one-cycle
//                completion pulse to the winning port. ctrl_lock masks new
//                core grants. A WAIT-state watchdog aborts stalled accesses.
//  Build option: ARBITER_ROUND_ROBIN_EN - when defined, ties alternate
//                between ports; otherwise the Controller always wins ties.
//  Ports       : clk, reset_n (sync, active low)
//                ctrl_lock                      - block core grants
//                ctrl_* / core_*                - requester buses
//                mem_*                          - memory bus
//                timeout_err                    - sticky abort flag
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ctrl_lock,
  input  logic                  ctrl_read,
  input  logic                  ctrl_write,
  input  logic [ADDR_WIDTH-1:0] ctrl_address,
  input  logic [DATA_WIDTH-1:0] ctrl_write_data,
  output logic [DATA_WIDTH-1:0] ctrl_read_data,
  output logic                  ctrl_response,
  input  logic                  core_read,
  input  logic                  core_write,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [DATA_WIDTH-1:0] core_write_data,
  output logic [DATA_WIDTH-1:0] core_read_data,
  output logic                  core_response,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_response,
  output logic                  timeout_err
);

  // Timer only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int TIMER_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 winner_core;   // port owning the current access
  logic [TIMER_W-1:0]   timer;

  logic                 ctrl_req;
  logic                 core_req;
  logic                 any_req;
  logic                 pick_core;
  logic                 sel_write;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_write_data;
  logic                 timeout_hit;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic                 last_grant_core;
`endif

  always_comb begin
    ctrl_req = ctrl_read | ctrl_write;
    core_req = (core_read | core_write) & ~ctrl_lock;
    any_req  = ctrl_req | core_req;
`ifdef ARBITER_ROUND_ROBIN_EN
    // On a tie the port that did not win last time gets the grant.
    pick_core = core_req & (~ctrl_req | ~last_grant_core);
`else
    pick_core = core_req & ~ctrl_req;
`endif
    // read&write together is treated as a write.
    sel_write      = pick_core ? core_write      : ctrl_write;
    sel_address    = pick_core ? core_address    : ctrl_address;
    sel_write_data = pick_core ? core_write_data : ctrl_write_data;
    timeout_hit    = (TIMEOUT_CYCLES != 0) &&
                     (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    state_next = state;
    case (state)
      S_IDLE:  if (any_req) state_next = S_WAIT;
      S_WAIT:  if (mem_response || timeout_hit) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    ctrl_response = (state == S_DONE) & ~winner_core;
    core_response = (state == S_DONE) &  winner_core;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      winner_core    <= 1'b0;
      timer          <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      ctrl_read_data <= '0;
      core_read_data <= '0;
      timeout_err    <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_grant_core <= 1'b1;
`endif
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            winner_core    <= pick_core;
            mem_address    <= sel_address;
            mem_write_data <= sel_write_data;
            mem_write      <= sel_write;
            mem_read       <= ~sel_write;
            timer          <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last_grant_core <= pick_core;
`endif
          end
        end
        S_WAIT: begin
          if (mem_response) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // mem_write still holds the op of this access.
            if (!mem_write) begin
              if (winner_core) core_read_data <= mem_read_data;
              else             ctrl_read_data <= mem_read_data;
            end
          end else if (timeout_hit) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            timeout_err <= 1'b1;
            if (winner_core) core_read_data <= '0;
            else             ctrl_read_data <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Scoreboard bench for memory_arbiter. Stimulus pushes expected
//                memory transactions and port responses into queues; a memory
//                responder and a response monitor pop and compare them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_lock = 1'b0;
  logic        ctrl_read = 1'b0, ctrl_write = 1'b0;
  logic [31:0] ctrl_address = '0, ctrl_write_data = '0;
  logic [31:0] ctrl_read_data;
  logic        ctrl_response;
  logic        core_read = 1'b0, core_write = 1'b0;
  logic [31:0] core_address = '0, core_write_data = '0;
  logic [31:0] core_read_data;
  logic        core_response;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_response = 1'b0;
  logic        timeout_err;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_lock(ctrl_lock),
    .ctrl_read(ctrl_read), .ctrl_write(ctrl_write),
    .ctrl_address(ctrl_address), .ctrl_write_data(ctrl_write_data),
    .ctrl_read_data(ctrl_read_data), .ctrl_response(ctrl_response),
    .core_read(core_read), .core_write(core_write),
    .core_address(core_address), .core_write_data(core_write_data),
    .core_read_data(core_read_data), .core_response(core_response),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_response(mem_response),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_t;

  typedef struct packed {
    logic        core;
    logic [31:0] data;
  } rsp_t;

  mem_t        mem_q[$];
  rsp_t        rsp_q[$];
  int          total = 0;
  int          bad = 0;
  bit          mem_mute = 1'b0;
  int          mem_lat = 2;
  logic [31:0] model_rd [2];

  task automatic chk(input bit ok, input string name,
                     input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one expected access: memory transaction plus port response.
  task automatic expect_acc(input bit core, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input bit tmo);
    mem_t m;
    rsp_t r;
    m.addr = addr; m.wr = wr; m.wdata = wdata; m.rdata = rdata;
    mem_q.push_back(m);
    if (tmo)      model_rd[core] = 32'h0;
    else if (!wr) model_rd[core] = rdata;
    r.core = core;
    r.data = model_rd[core];
    rsp_q.push_back(r);
  endtask

  // Hold a request until its response pulse (bounded), then drop it.
  task automatic drive(input bit core, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int bound, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    if (core) begin
      core_read = rd; core_write = wr; core_address = addr; core_write_data = wdata;
    end else begin
      ctrl_read = rd; ctrl_write = wr; ctrl_address = addr; ctrl_write_data = wdata;
    end
    while (!got && n < bound) begin
      @(posedge clk); #1;
      n++;
      got = core ? core_response : ctrl_response;
    end
    chk(got, core ? "core_resp_wait" : "ctrl_resp_wait", 160'(n), 160'(bound));
    if (core) begin core_read = 1'b0; core_write = 1'b0; end
    else      begin ctrl_read = 1'b0; ctrl_write = 1'b0; end
  endtask

  initial begin
    int n0, n1, cnt;
    bit seen;
    model_rd[0] = '0;
    model_rd[1] = '0;

    fork
      // Response monitor
      begin
        rsp_t r;
        forever begin
          @(negedge clk);
          if (ctrl_response || core_response) begin
            chk(!(ctrl_response && core_response), "dual_resp",
                160'({ctrl_response, core_response}), 160'(0));
            chk(rsp_q.size() != 0, "unexpected_resp",
                160'({ctrl_response, core_response}), 160'(0));
            if (rsp_q.size() != 0) begin
              r = rsp_q.pop_front();
              chk(core_response == r.core &&
                  (core_response ? core_read_data : ctrl_read_data) == r.data,
                  "resp",
                  160'({core_response, core_response ? core_read_data : ctrl_read_data}),
                  160'({r.core, r.data}));
            end
          end
        end
      end
      // Memory responder
      begin
        mem_t m;
        bit prev, cur;
        prev = 1'b0;
        forever begin
          @(posedge clk); #1;
          cur = mem_read | mem_write;
          if (cur && !prev) begin
            chk(mem_q.size() != 0, "unexpected_mem",
                160'({mem_address, mem_write, mem_read}), 160'(0));
            if (mem_q.size() != 0) begin
              m = mem_q.pop_front();
              chk({mem_address, mem_write, mem_read, mem_write_data} ==
                  {m.addr, m.wr, ~m.wr, m.wdata}, "mem_req",
                  160'({mem_address, mem_write, mem_read, mem_write_data}),
                  160'({m.addr, m.wr, ~m.wr, m.wdata}));
              if (!mem_mute) begin
                repeat (mem_lat - 1) begin @(posedge clk); #1; end
                mem_response  = 1'b1;
                mem_read_data = m.rdata;
                @(posedge clk); #1;
                mem_response  = 1'b0;
                mem_read_data = 32'h0BAD_0BAD;
                cur = mem_read | mem_write;
              end
            end
          end
          prev = cur;
        end
      end
      // Watchdog
      begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk({mem_read, mem_write, mem_address, mem_write_data, ctrl_read_data,
         core_read_data, ctrl_response, core_response, timeout_err} == '0,
        "reset_state",
        160'({mem_read, mem_write, mem_address, mem_write_data, ctrl_read_data,
              core_read_data, ctrl_response, core_response, timeout_err}), 160'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: core read, memory answers 2 cycles after strobe
    mem_lat = 2;
    expect_acc(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 20, n0);
    chk(n0 == 3, "t1_latency", 160'(n0), 160'(3));
    repeat (3) @(posedge clk); #1;
    chk(core_read_data == 32'hDEAD_BEEF, "t1_hold", 160'(core_read_data), 160'(32'hDEAD_BEEF));

    // 2: simultaneous writes after a core grant -> Controller first
    expect_acc(1'b0, 1'b1, 32'h4, 32'h11, 32'h9999_9999, 1'b0);
    expect_acc(1'b1, 1'b1, 32'h8, 32'h22, 32'h8888_8888, 1'b0);
    fork
      drive(1'b0, 1'b0, 1'b1, 32'h4, 32'h11, 20, n0);
      drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h22, 20, n1);
    join
    chk(n1 > n0, "t2_order", 160'({n0, n1}), 160'(0));

    // Controller-only read, then another tie: fixed -> ctrl, RR -> core first
    expect_acc(1'b0, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 20, n0);
`ifdef ARBITER_ROUND_ROBIN_EN
    expect_acc(1'b1, 1'b1, 32'h8, 32'h44, 32'h7777_7777, 1'b0);
    expect_acc(1'b0, 1'b1, 32'h4, 32'h33, 32'h6666_6666, 1'b0);
`else
    expect_acc(1'b0, 1'b1, 32'h4, 32'h33, 32'h6666_6666, 1'b0);
    expect_acc(1'b1, 1'b1, 32'h8, 32'h44, 32'h7777_7777, 1'b0);
`endif
    fork
      drive(1'b0, 1'b0, 1'b1, 32'h4, 32'h33, 20, n0);
      drive(1'b1, 1'b0, 1'b1, 32'h8, 32'h44, 20, n1);
    join

    // 6: read&write together on ctrl -> write, read data unchanged
    expect_acc(1'b0, 1'b1, 32'h20, 32'h55, 32'h1234_5678, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h55, 20, n0);
    #2;
    chk(ctrl_read_data == 32'hCAFE_F00D, "t6_rdata_kept",
        160'(ctrl_read_data), 160'(32'hCAFE_F00D));
    @(posedge clk); #1;

    // 3: lock blocks core for 50 cycles, then core served promptly
    ctrl_lock = 1'b1;
    core_read = 1'b1; core_address = 32'h40;
    cnt = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (mem_read || mem_write || core_response) cnt++;
    end
    chk(cnt == 0, "t3_locked_quiet", 160'(cnt), 160'(0));
    expect_acc(1'b1, 1'b0, 32'h40, 32'h0, 32'hA5A5_5A5A, 1'b0);
    ctrl_lock = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3 + mem_lat, n0);
    chk(n0 <= 3 + mem_lat, "t3_unlock_latency", 160'(n0), 160'(3 + mem_lat));

    // Lock raised mid-transaction does not abort a granted core access
    mem_lat = 3;
    expect_acc(1'b1, 1'b0, 32'h44, 32'h0, 32'h0F0F_0F0F, 1'b0);
    fork
      drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 20, n0);
      begin
        repeat (2) begin @(posedge clk); #1; end
        ctrl_lock = 1'b1;
      end
    join
    ctrl_lock = 1'b0;
    chk(timeout_err == 1'b0, "no_timeout_yet", 160'(timeout_err), 160'(0));

    // 4: ctrl read with no memory answer -> abort after 8 WAIT cycles
    mem_mute = 1'b1;
    expect_acc(1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 1'b1);
    cnt = 0;
    fork
      drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 30, n0);
      repeat (20) begin
        @(posedge clk); #1;
        if (mem_read) cnt++;
      end
    join
    mem_mute = 1'b0;
    chk(cnt == 8, "t4_strobe_cycles", 160'(cnt), 160'(8));
    chk(timeout_err == 1'b1, "t4_timeout_err", 160'(timeout_err), 160'(1));
    mem_lat = 1;
    expect_acc(1'b0, 1'b0, 32'h60, 32'h0, 32'h1111_2222, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 20, n0);
    chk(timeout_err == 1'b1, "t4_sticky", 160'(timeout_err), 160'(1));

    // 5: reset during WAIT drops the access; late mem_response ignored
    mem_lat = 4;
    begin
      mem_t m;
      m.addr = 32'h70; m.wr = 1'b0; m.wdata = 32'h0; m.rdata = 32'h7777_0000;
      mem_q.push_back(m);
    end
    ctrl_read = 1'b1; ctrl_address = 32'h70;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_read;
    end
    chk(seen, "t5_strobe_seen", 160'(seen), 160'(1));
    reset_n = 1'b0;
    ctrl_read = 1'b0;
    @(posedge clk); #1;
    chk({mem_read, mem_write, mem_address, mem_write_data, ctrl_read_data,
         core_read_data, ctrl_response, core_response, timeout_err} == '0,
        "t5_reset_outputs",
        160'({mem_read, mem_write, mem_address, mem_write_data, ctrl_read_data,
              core_read_data, ctrl_response, core_response, timeout_err}), 160'(0));
    reset_n = 1'b1;
    model_rd[0] = '0;
    model_rd[1] = '0;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) cnt++;
    end
    chk(cnt == 0, "t5_idle_after_reset", 160'(cnt), 160'(0));

    // Normal operation after reset
    mem_lat = 2;
    expect_acc(1'b1, 1'b0, 32'h80, 32'h0, 32'h5555_AAAA, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 20, n0);
    repeat (4) @(posedge clk);
    #1;
    chk(rsp_q.size() == 0 && mem_q.size() == 0, "queues_drained",
        160'({rsp_q.size(), mem_q.size()}), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
